// File: rtl/data_split_if.sv
// Byte-in / dibit-out bus of the data_split serializer.
// The master side offers bytes and observes the dibit stream; the slave side is the serializer.
interface data_split_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] dout;
  logic       dout_en;
  logic       busy;

  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_en, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_en, busy
  );
endinterface

// File: rtl/data_split.sv
// Byte-to-dibit serializer: FIFO-buffered bytes leave as four back-to-back 2-bit beats, MSB dibit first.
//
// state    | meaning
// ST_IDLE  | nothing in flight, shifter cleared, dout_en low
// ST_SHIFT | presenting sh_q[7:6], cnt_q counts the dibit index 0..3 of the current byte
module data_split #(
  parameter int DEPTH_LOG2 = 2
) (
  input logic         clk,
  input logic         rstn,
  data_split_if.slave bus
);

  localparam int                  DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            sh_q, sh_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  shifting;

  // Ready looks only at the registered count, so a full FIFO refuses even during a pop.
  assign bus.din_ready = (count_q != FULL);
  assign push          = bus.din_valid & bus.din_ready;
  assign fifo_empty    = (count_q == '0);
  assign shifting      = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sh_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          cnt_d   = 2'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_q << 2;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Reload on the last dibit so consecutive bytes stream without a gap.
          if (!fifo_empty) begin
            pop   = 1'b1;
            sh_d  = mem_q[rd_ptr_q];
            cnt_d = 2'd0;
          end else begin
            sh_d    = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        sh_d    = '0;
        cnt_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sh_q     <= '0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The shifter is zero whenever idle, so dout needs no gating.
  assign bus.dout    = sh_q[7:6];
  assign bus.dout_en = shifting;
  assign bus.busy    = !fifo_empty | shifting;

endmodule
